byte_framer: RTL



---
 rtl/byte_framer_if.sv | 26 ++
 rtl/byte_framer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/byte_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : byte_framer_if
// Description : Upstream and downstream valid/ready byte streams of byte_framer.
// Revision    : 1.0 - initial release
// ============================================================================
interface byte_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    // master: the framer itself; slave: the environment around it
    modport master (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );
    modport slave (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface
`default_nettype wire

// File: rtl/byte_framer.sv
`default_nettype none
// ============================================================================
// Module      : byte_framer
// Description : Groups bytes into PAYLOAD_LEN frames behind a HEADER byte, with
//               an optional XOR trailer enabled by BYTE_FRAMER_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_framer #(
    parameter int         PAYLOAD_LEN = 4,
    parameter logic [7:0] HEADER      = 8'h7E
) (
    input  wire           clk,
    input  wire           rst,
    byte_framer_if.master bus,
    output logic [15:0]   frame_count
);

`ifdef BYTE_FRAMER_CHKSUM_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;
`endif

    localparam logic [7:0] C_LAST_IDX = 8'(PAYLOAD_LEN - 1);

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] frame_count_q, frame_count_d;
`ifdef BYTE_FRAMER_CHKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    logic w_slot_free;
    logic w_up_xfer;
    logic w_dn_xfer;

    assign w_slot_free = !valid_q || bus.m_ready;
    assign w_dn_xfer   = valid_q && bus.m_ready;
    // Upstream stalls combinationally as soon as the output slot is blocked
    assign bus.s_ready = (state_q == PAYLOAD) && w_slot_free;
    assign w_up_xfer   = bus.s_valid && bus.s_ready;

    assign bus.m_data  = data_q;
    assign bus.m_valid = valid_q;
    assign bus.m_last  = last_q;
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        valid_d       = valid_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
`ifdef BYTE_FRAMER_CHKSUM_EN
        chk_d         = chk_q;
`endif

        if (w_slot_free) begin
            valid_d = 1'b0;
        end
        if (w_dn_xfer && last_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (bus.s_valid && w_slot_free) begin
                    data_d  = HEADER;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    cnt_d   = 8'd0;
`ifdef BYTE_FRAMER_CHKSUM_EN
                    chk_d   = 8'h00;
`endif
                    state_d = HDR;
                end
            end
            HDR: begin
                if (w_dn_xfer) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_up_xfer) begin
                    data_d  = bus.s_data;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
`ifdef BYTE_FRAMER_CHKSUM_EN
                    chk_d   = chk_q ^ bus.s_data;
                    last_d  = 1'b0;
                    if (cnt_q == C_LAST_IDX) begin
                        state_d = CHK;
                    end
`else
                    last_d  = (cnt_q == C_LAST_IDX);
                    if (cnt_q == C_LAST_IDX) begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef BYTE_FRAMER_CHKSUM_EN
            CHK: begin
                // chk_q already folds in the final payload byte
                if (w_slot_free) begin
                    data_d  = chk_q;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            cnt_q         <= 8'd0;
            frame_count_q <= 16'd0;
`ifdef BYTE_FRAMER_CHKSUM_EN
            chk_q         <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
`ifdef BYTE_FRAMER_CHKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

endmodule
`default_nettype wire
